// File: rtl/rom_8x16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rom_pkg
//  Purpose  : Shared sizing constants and the fixed instruction-word contents
//             of the 8 x 16 program ROM.
//  Contents : DATA_W      - instruction word width (16 only)
//             ADDR_W      - address width (3)
//             DEPTH       - number of words (2**ADDR_W = 8)
//             ROM_CONTENT - the eight constant program words, address order
//  Revision : 1.0 - initial release
// ============================================================================
package rom_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [DATA_W-1:0] ROM_CONTENT [DEPTH] = '{
    16'h1101, 16'h1202, 16'h2312, 16'h3400,
    16'h4512, 16'h5600, 16'h6000, 16'hF000
  };

endpackage : rom_pkg
`default_nettype wire

// File: rtl/rom_8x16_if.sv
`default_nettype none
// ============================================================================
//  Module   : rom_8x16_if
//  Purpose  : Fetch bus between an instruction fetcher and the program ROM.
//  Signals  : enr        - read enable (fetch word at pc this cycle)
//             pc         - word address
//             data       - registered instruction word
//             data_valid - data holds the word fetched on the previous edge
//  Modports : master - fetcher side (drives enr/pc)
//             slave  - ROM side (drives data/data_valid)
//  Revision : 1.0 - initial release
// ============================================================================
interface rom_8x16_if
  import rom_pkg::*;
#(
  parameter int DATA_W = rom_pkg::DATA_W,
  parameter int ADDR_W = rom_pkg::ADDR_W
);

  logic              enr;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] data;
  logic              data_valid;

  modport master (
    output enr,
    output pc,
    input  data,
    input  data_valid
  );

  modport slave (
    input  enr,
    input  pc,
    output data,
    output data_valid
  );

endinterface : rom_8x16_if
`default_nettype wire

// File: rtl/rom_8x16_table.sv
`default_nettype none
// ============================================================================
//  Module   : rom_table
//  Purpose  : Purely combinational address-to-word lookup of the fixed
//             program contents. Carries no state and no reset.
//  Ports    : pc   (in)  - word address
//             word (out) - instruction word stored at pc
//  Revision : 1.0 - initial release
// ============================================================================
module rom_table
  import rom_pkg::*;
#(
  parameter int DATA_W = rom_pkg::DATA_W,
  parameter int ADDR_W = rom_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] word
);

  always_comb begin
    word = '0;
    case (pc)
      ADDR_W'(0): word = ROM_CONTENT[0];
      ADDR_W'(1): word = ROM_CONTENT[1];
      ADDR_W'(2): word = ROM_CONTENT[2];
      ADDR_W'(3): word = ROM_CONTENT[3];
      ADDR_W'(4): word = ROM_CONTENT[4];
      ADDR_W'(5): word = ROM_CONTENT[5];
      ADDR_W'(6): word = ROM_CONTENT[6];
      ADDR_W'(7): word = ROM_CONTENT[7];
      default:    word = '0;
    endcase
  end

endmodule : rom_table
`default_nettype wire

// File: rtl/rom_8x16.sv
`default_nettype none
// ============================================================================
//  Module   : rom_8x16
//  Purpose  : 8 x 16 read-only program memory with one-cycle registered read.
//             An enabled edge captures word[pc] and raises data_valid for one
//             cycle; a disabled edge holds data and drops data_valid.
//  Ports    : clk   (in)  - clock, rising edge
//             rst_n (in)  - synchronous active-low reset (clears data/valid)
//             bus   (slave modport of rom_8x16_if) - enr, pc, data, data_valid
//  Revision : 1.0 - initial release
// ============================================================================
module rom_8x16
  import rom_pkg::*;
#(
  parameter int DATA_W = rom_pkg::DATA_W,
  parameter int ADDR_W = rom_pkg::ADDR_W
) (
  input  logic       clk,
  input  logic       rst_n,
  rom_8x16_if.slave  bus
);

  logic [DATA_W-1:0] rom_word;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;
  logic              data_valid_d;
  logic              data_valid_q;

  rom_table #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rom_table (
    .pc   (bus.pc),
    .word (rom_word)
  );

  // Disabled cycles keep the last fetched word so the consumer can still
  // read it; only the valid flag signals freshness.
  always_comb begin
    data_d       = data_q;
    data_valid_d = 1'b0;
    if (bus.enr) begin
      data_d       = rom_word;
      data_valid_d = 1'b1;
    end
  end

  // Reset wins over a same-cycle read request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;

endmodule : rom_8x16
`default_nettype wire

// File: tb/tb_rom_8x16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_8x16
//  Purpose  : Self-checking bench for rom_8x16 - directed scenarios followed
//             by randomized reset/enable/address traffic against a
//             cycle-level reference model of the fetch behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_8x16;

  logic clk;
  logic rst_n;

  rom_8x16_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  rom_8x16 #(
    .DATA_W (16),
    .ADDR_W (3)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference contents, written out independently of the design package.
  logic [15:0] ref_rom [8];
  logic [15:0] exp_data;
  logic        exp_valid;
  int          n_vec;
  int          n_err;

  task automatic check_val(input string tag, input logic [15:0] obs,
                           input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, then compare.
  task automatic step(input logic r, input logic en, input logic [2:0] addr,
                      input string tag);
    rst_n   = r;
    bus.enr = en;
    bus.pc  = addr;
    @(posedge clk);
    if (!r) begin
      exp_data  = 16'h0000;
      exp_valid = 1'b0;
    end else if (en) begin
      exp_data  = ref_rom[addr];
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
    check_val({tag, ".data"}, bus.data, exp_data);
    check_val({tag, ".valid"}, {15'd0, bus.data_valid}, {15'd0, exp_valid});
  endtask

  initial begin
    ref_rom[0] = 16'h1101; ref_rom[1] = 16'h1202;
    ref_rom[2] = 16'h2312; ref_rom[3] = 16'h3400;
    ref_rom[4] = 16'h4512; ref_rom[5] = 16'h5600;
    ref_rom[6] = 16'h6000; ref_rom[7] = 16'hF000;
    n_vec     = 0;
    n_err     = 0;
    exp_data  = 16'h0000;
    exp_valid = 1'b0;

    // Reset held two edges with a pending read request.
    step(1'b0, 1'b1, 3'd5, "reset0");
    step(1'b0, 1'b1, 3'd5, "reset1");

    // Back-to-back reads straight out of reset.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'(i), "seq");

    // Hold on disabled edge.
    step(1'b1, 1'b1, 3'd4, "rd4");
    step(1'b1, 1'b0, 3'd6, "hold");
    step(1'b1, 1'b0, 3'd1, "hold2");

    // Wrap from top address back to zero is an ordinary read.
    step(1'b1, 1'b1, 3'd7, "rd7");
    step(1'b1, 1'b1, 3'd0, "rd0");

    // Mid-stream single-edge reset, then resume.
    step(1'b1, 1'b1, 3'd5, "pre_rst");
    step(1'b0, 1'b1, 3'd6, "mid_rst");
    step(1'b1, 1'b1, 3'd6, "resume");

    // pc changes between edges must not reach data.
    step(1'b1, 1'b1, 3'd2, "rd2");
    bus.pc = 3'd3;
    #2;
    check_val("no_comb_pc", bus.data, 16'h2312);
    bus.enr = 1'b0;
    #1;
    check_val("no_comb_enr", {15'd0, bus.data_valid}, 16'd1);
    step(1'b1, 1'b1, 3'd6, "sampled_pc");

    // Randomized traffic: occasional resets, mostly enabled reads.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rom_8x16
`default_nettype wire

// File: doc/rom_8x16.md
ROM_8X16 -- requirements
Module: rom_8x16

Interface
REQ-001 Parameter DATA_W, default 16, instruction word width; only 16 supported.
REQ-002 Parameter ADDR_W, default 3, address width; depth = 2**ADDR_W = 8 words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enr  input  1  read enable; high = fetch word at pc this cycle.
REQ-006 pc  input  ADDR_W  word address (program counter).
REQ-007 data  output  DATA_W  registered instruction word.
REQ-008 data_valid  output  1  high for one cycle when data holds a word fetched on the previous edge.

Function
REQ-009 Contents are fixed at elaboration, read-only, no write port: addr0=16'h1101, 1=16'h1202, 2=16'h2312, 3=16'h3400, 4=16'h4512, 5=16'h5600, 6=16'h6000, 7=16'hF000.
REQ-010 Read latency is one cycle: on a rising edge with rst_n=1 and enr=1, data <= word[pc] and data_valid <= 1.
REQ-011 On a rising edge with rst_n=1 and enr=0, data holds its previous value and data_valid <= 0.
REQ-012 pc is sampled only at the rising edge; pc changes between edges have no effect on data.
REQ-013 Every pc value 0..7 is in range; no out-of-range case exists, and there is no error output.
REQ-014 A different pc on every consecutive enabled edge yields a new word every cycle (full throughput, no stall).
REQ-015 The address does not auto-increment; pc 7 followed by pc 0 is an ordinary read of word 0.
REQ-016 No combinational path from pc or enr to data or data_valid.
REQ-017 Outputs contain no X at any time after the first reset edge.

Reset
REQ-018 On a rising edge with rst_n=0: data <= 16'h0000 and data_valid <= 0, regardless of enr and pc.
REQ-019 Reset has priority over enr; a read requested in the same cycle as reset is discarded.
REQ-020 After rst_n deasserts, the first enabled edge produces valid data on the following cycle; no warm-up cycles.
REQ-021 Contents are constant and unaffected by reset.

Structure
REQ-022 Package rom_pkg holds DATA_W, ADDR_W, DEPTH and the 8-entry content constant array.
REQ-023 Sub-module rom_table: purely combinational address-to-word lookup (case on pc); rom_8x16 instantiates it and adds the output register and valid logic.
REQ-024 Synthesizable; infers LUT/ROM logic plus 17 flip-flops.

Verification
REQ-025 Hold rst_n=0 for 2 edges with enr=1, pc=5 -> data=16'h0000, data_valid=0.
REQ-026 After reset, enr=1, pc=0,1,2,3 on consecutive edges -> data=16'h1101,16'h1202,16'h2312,16'h3400 one cycle after each, data_valid=1 throughout.
REQ-027 Read pc=4 (data=16'h4512), then enr=0 with pc=6 -> data stays 16'h4512, data_valid=0.
REQ-028 enr=1, pc=7 then pc=0 -> data=16'hF000 then 16'h1101.
REQ-029 Mid-stream rst_n=0 for one edge during enabled reads -> data=16'h0000, data_valid=0 that cycle; reading resumes correctly on the next enabled edge.
REQ-030 Change pc between clock edges with enr=1 -> data changes only after the next rising edge, to the word for the sampled pc.
